// File: rtl/modem_demod.sv
// modem_demod: recovers one bit per symbol from 7-bit unsigned carrier samples.
// The bit comes from ASK energy, FSK midscale crossings or BPSK split-half correlation.
module modem_demod #(
    parameter int SPS     = 16,
    parameter int MID     = 64,
    parameter int ASK_THR = 256,
    parameter int FSK_THR = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic [6:0] sample_in,
    input  logic       sample_valid,
    input  logic       sym_start,
    output logic       demod_out,
    output logic       bit_valid,
    output logic       busy
);
    localparam int IDX_W = $clog2(SPS);
    localparam int ASK_W = IDX_W + 7;
    localparam int COR_W = IDX_W + 8;
    localparam logic [1:0] SEL_ASK  = 2'b00;
    localparam logic [1:0] SEL_FSK  = 2'b01;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sel_q, sel_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ASK_W-1:0]        ask_q, ask_d;
    logic [3:0]              cnt_q, cnt_d;
    logic signed [COR_W-1:0] cor_q, cor_d;
    logic                    prev_sign_q, prev_sign_d;
    logic                    demod_out_q, demod_out_d;
    logic                    bit_valid_q, bit_valid_d;

    logic signed [7:0]       diff;
    logic                    sgn, abort, accept, first, last;
    logic [IDX_W-1:0]        idx_cur;
    logic [ASK_W-1:0]        ask_base, ask_new;
    logic [3:0]              cnt_base, cnt_new;
    logic signed [COR_W-1:0] cor_base, cor_new, diff_x;

    // |-64| = 64 still fits the unsigned 8-bit result
    function automatic logic [7:0] abs8(input logic signed [7:0] v);
        return v[7] ? -v : v;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    always_comb begin
        sel_d    = sel;
        diff     = $signed({1'b0, sample_in}) - signed'(8'(MID));
        sgn      = (int'(sample_in) >= MID);
        abort    = (sel != sel_q);
        accept   = sample_valid && !abort && (sel != SEL_IDLE);
        // a sym_start sample restarts the symbol from index 0
        first    = (state_q == IDLE) || sym_start;
        idx_cur  = first ? '0 : idx_q;
        ask_base = first ? '0 : ask_q;
        cnt_base = first ? '0 : cnt_q;
        cor_base = first ? '0 : cor_q;
        diff_x   = COR_W'(diff);
        ask_new  = ask_base + ASK_W'(abs8(diff));
        cnt_new  = (sgn != prev_sign_q) ? sat_inc4(cnt_base) : cnt_base;
        cor_new  = idx_cur[IDX_W-1] ? cor_base - diff_x : cor_base + diff_x;
        last     = (idx_cur == IDX_W'(SPS - 1));

        state_d     = state_q;
        idx_d       = idx_q;
        ask_d       = ask_q;
        cnt_d       = cnt_q;
        cor_d       = cor_q;
        prev_sign_d = prev_sign_q;
        demod_out_d = demod_out_q;
        bit_valid_d = 1'b0;

        if (abort || sel == SEL_IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
            ask_d   = '0;
            cnt_d   = '0;
            cor_d   = '0;
        end else if (accept) begin
            prev_sign_d = sgn;
            if (last) begin
                state_d     = IDLE;
                idx_d       = '0;
                ask_d       = '0;
                cnt_d       = '0;
                cor_d       = '0;
                bit_valid_d = 1'b1;
                case (sel)
                    SEL_ASK: demod_out_d = (int'(ask_new) >= ASK_THR);
                    SEL_FSK: demod_out_d = (int'(cnt_new) >= FSK_THR);
                    default: demod_out_d = cor_new[COR_W-1];
                endcase
            end else begin
                state_d = ACCUM;
                idx_d   = idx_cur + 1'b1;
                ask_d   = ask_new;
                cnt_d   = cnt_new;
                cor_d   = cor_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= SEL_IDLE;
            idx_q       <= '0;
            ask_q       <= '0;
            cnt_q       <= '0;
            cor_q       <= '0;
            prev_sign_q <= 1'b0;
            demod_out_q <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            ask_q       <= ask_d;
            cnt_q       <= cnt_d;
            cor_q       <= cor_d;
            prev_sign_q <= prev_sign_d;
            demod_out_q <= demod_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign demod_out = demod_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = (state_q == ACCUM);
endmodule

// File: tb/tb_modem_demod.sv
// Testbench for modem_demod: table of symbols plus scoreboard of expected bits,
// followed by abort, realignment/gap and asynchronous reset sequences.
module tb_modem_demod;
    localparam int SPS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic [6:0] sample_in;
    logic       sample_valid;
    logic       sym_start;
    logic       demod_out;
    logic       bit_valid;
    logic       busy;

    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;
    logic exp_q[$];
    logic [1:0] cur_sel;

    typedef struct {
        logic [1:0] sel;
        logic [6:0] a;
        logic [6:0] b;
        int         h;
        logic       exp;
    } vec_t;

    vec_t tbl[16];
    int   gpos[3];

    always #5 clk = ~clk;

    modem_demod #(.SPS(SPS), .MID(64), .ASK_THR(256), .FSK_THR(3)) dut (
        .clk(clk), .reset(reset), .sel(sel), .sample_in(sample_in),
        .sample_valid(sample_valid), .sym_start(sym_start),
        .demod_out(demod_out), .bit_valid(bit_valid), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // every bit_valid pulse must match the oldest outstanding expected bit
    always @(negedge clk) begin
        if (bit_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) check("unexpected_bit_valid", bit_valid, 0);
            else check("demod_bit", demod_out, exp_q.pop_front());
        end
    end

    task automatic cyc(input logic [1:0] s, input logic v, input logic [6:0] x, input logic st);
        sel          = s;
        sample_valid = v;
        sample_in    = x;
        sym_start    = st;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] s);
        if (s !== cur_sel) begin
            cyc(s, 1'b0, 7'd64, 1'b0);
            cur_sel = s;
        end
    endtask

    task automatic run_sym(input logic [1:0] s, input logic [6:0] a, input logic [6:0] b,
                           input int h, input logic e);
        set_mode(s);
        for (int i = 0; i < SPS; i++) begin
            if (i == SPS - 1) exp_q.push_back(e);
            cyc(s, 1'b1, ((i / h) % 2 == 0) ? a : b, 1'b0);
            if (i == SPS / 2) check("busy_mid", busy, 1);
            if (i == SPS - 2) check("no_early_pulse", bit_valid, 0);
        end
        check("pulse_timing", bit_valid, 1);
        check("busy_after", busy, 0);
        cyc(s, 1'b0, 7'd64, 1'b0);
        check("pulse_width", bit_valid, 0);
    endtask

    initial begin
        // FSK results depend on prev_sign carried over from the previous row
        tbl[0]  = '{2'b01, 7'd80,  7'd48,  8,  1'b0};
        tbl[1]  = '{2'b01, 7'd80,  7'd48,  4,  1'b1};
        tbl[2]  = '{2'b01, 7'd48,  7'd80,  5,  1'b1};
        tbl[3]  = '{2'b01, 7'd80,  7'd48,  6,  1'b0};
        tbl[4]  = '{2'b01, 7'd48,  7'd80,  1,  1'b1};
        tbl[5]  = '{2'b00, 7'd104, 7'd24,  1,  1'b1};
        tbl[6]  = '{2'b00, 7'd64,  7'd64,  16, 1'b0};
        tbl[7]  = '{2'b00, 7'd80,  7'd48,  1,  1'b1};
        tbl[8]  = '{2'b00, 7'd79,  7'd49,  1,  1'b0};
        tbl[9]  = '{2'b00, 7'd0,   7'd127, 1,  1'b1};
        tbl[10] = '{2'b10, 7'd100, 7'd28,  8,  1'b0};
        tbl[11] = '{2'b10, 7'd28,  7'd100, 8,  1'b1};
        tbl[12] = '{2'b10, 7'd64,  7'd64,  16, 1'b0};
        tbl[13] = '{2'b10, 7'd64,  7'd65,  8,  1'b1};
        tbl[14] = '{2'b10, 7'd65,  7'd64,  8,  1'b0};
        tbl[15] = '{2'b10, 7'd0,   7'd127, 8,  1'b1};
        for (int j = 0; j < 3; j++) gpos[j] = int'($urandom_range(1, SPS - 2));

        reset = 1'b1; sel = 2'b11; sample_in = 7'd0; sample_valid = 1'b0; sym_start = 1'b0;
        cur_sel = 2'b11;
        #12;
        check("rst_demod_out", demod_out, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 16; v++)
            run_sym(tbl[v].sel, tbl[v].a, tbl[v].b, tbl[v].h, tbl[v].exp);

        // mode abort: partial ASK symbol, then a switch cycle whose sample is dropped
        set_mode(2'b00);
        for (int i = 0; i < 5; i++) cyc(2'b00, 1'b1, 7'd104, 1'b0);
        cyc(2'b01, 1'b1, 7'd10, 1'b0);
        cur_sel = 2'b01;
        check("abort_busy", busy, 0);
        check("abort_no_pulse", bit_valid, 0);
        run_sym(2'b01, 7'd48, 7'd80, 6, 1'b1);

        // realignment with sample gaps
        set_mode(2'b00);
        for (int i = 0; i < 6; i++) cyc(2'b00, 1'b1, 7'd127, 1'b0);
        cyc(2'b00, 1'b1, 7'd64, 1'b1);
        check("busy_realign", busy, 1);
        for (int k = 1; k < SPS; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (gpos[j] == k) begin
                    cyc(2'b00, 1'b0, 7'd0, 1'b0);
                    check("busy_gap", busy, 1);
                end
            end
            if (k == SPS - 1) exp_q.push_back(1'b0);
            cyc(2'b00, 1'b1, 7'd64, 1'b0);
            if (k == SPS - 2) check("realign_no_early", bit_valid, 0);
        end
        check("realign_pulse", bit_valid, 1);
        cyc(2'b00, 1'b0, 7'd64, 1'b0);

        // asynchronous reset mid-symbol after a 1 has been decided
        run_sym(2'b00, 7'd104, 7'd24, 1, 1'b1);
        check("pre_reset_demod", demod_out, 1);
        for (int i = 0; i < 5; i++) cyc(2'b00, 1'b1, 7'd104, 1'b0);
        check("pre_reset_busy", busy, 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_demod_out", demod_out, 0);
        check("async_busy", busy, 0);
        check("async_bit_valid", bit_valid, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cur_sel = 2'b11;
        for (int i = 0; i < 20; i++) cyc(2'b11, 1'b1, (i % 2 == 0) ? 7'd120 : 7'd5, 1'b0);
        check("idle_busy", busy, 0);
        check("idle_demod", demod_out, 0);
        run_sym(2'b00, 7'd104, 7'd24, 1, 1'b1);

        repeat (2) cyc(2'b00, 1'b0, 7'd64, 1'b0);
        check("pulse_count", pulses, 20);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
